// File: rtl/nonce_search_ctrl.sv
// Sequencer for NUM_LANES parallel double-SHA-256 lanes: steps rounds and blocks,
// issues nonce batches, compares lane digests to the target and records the first hit.
module nonce_search_ctrl #(
    parameter int NUM_LANES      = 10,
    parameter int ROUNDS         = 64,
    parameter int MIDSTATE_REUSE = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     stop_on_find,
    input  logic [31:0]              nonce_start,
    input  logic [31:0]              nonce_end,
    input  logic [255:0]             target,
    input  logic [NUM_LANES*256-1:0] lane_hash,
    output logic [6:0]               select,
    output logic [1:0]               block,
    output logic [31:0]              nonce_base,
    output logic [NUM_LANES-1:0]     lane_valid,
    output logic                     busy,
    output logic                     found,
    output logic [31:0]              found_nonce,
    output logic [4:0]               found_lane,
    output logic                     done,
    output logic [31:0]              batch_cnt
);

    localparam logic [6:0]  LAST_SEL  = 7'(ROUNDS + 1);
    localparam logic [32:0] LANE_SPAN = 33'(NUM_LANES - 1);
    localparam logic [31:0] LANE_STEP = 32'(NUM_LANES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BLK0,
        S_BLK1,
        S_BLK2,
        S_CMP,
        S_FIN
    } state_t;

    state_t         state_q, state_d;
    logic [6:0]     select_q, select_d;
    logic [1:0]     block_q, block_d;
    logic [31:0]    nonce_base_q, nonce_base_d;
    logic [31:0]    nonce_end_q, nonce_end_d;
    logic [255:0]   target_q, target_d;
    logic           busy_q, busy_d;
    logic           found_q, found_d;
    logic [31:0]    found_nonce_q, found_nonce_d;
    logic [4:0]     found_lane_q, found_lane_d;
    logic           done_q, done_d;
    logic [31:0]    batch_cnt_q, batch_cnt_d;

    logic [NUM_LANES-1:0] hit_vec;
    logic                 any_hit;
    logic [4:0]           win_lane;
    logic                 last_batch;

    // Lane masking uses 33-bit sums so a batch near 2^32 never wraps into validity.
    always_comb begin
        lane_valid = '0;
        hit_vec    = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_valid[i] = ({1'b0, nonce_base_q} + 33'(i)) <= {1'b0, nonce_end_q};
            hit_vec[i]    = lane_valid[i] && (lane_hash[i*256 +: 256] < target_q);
        end
    end

    always_comb begin
        any_hit  = |hit_vec;
        win_lane = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                win_lane = 5'(i);
            end
        end
        last_batch = ({1'b0, nonce_base_q} + LANE_SPAN) >= {1'b0, nonce_end_q};
    end

    always_comb begin
        state_d       = state_q;
        select_d      = '0;
        nonce_base_d  = nonce_base_q;
        nonce_end_d   = nonce_end_q;
        target_d      = target_q;
        found_d       = found_q;
        found_nonce_d = found_nonce_q;
        found_lane_d  = found_lane_q;
        batch_cnt_d   = batch_cnt_q;

        if (state_q != S_IDLE && abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        nonce_base_d  = nonce_start;
                        nonce_end_d   = nonce_end;
                        target_d      = target;
                        found_d       = 1'b0;
                        found_nonce_d = '0;
                        found_lane_d  = '0;
                        batch_cnt_d   = '0;
                        state_d       = (nonce_end < nonce_start) ? S_FIN : S_BLK0;
                    end
                end
                S_BLK0, S_BLK1, S_BLK2: begin
                    if (select_q == LAST_SEL) begin
                        case (state_q)
                            S_BLK0:  state_d = S_BLK1;
                            S_BLK1:  state_d = S_BLK2;
                            default: state_d = S_CMP;
                        endcase
                    end else begin
                        select_d = select_q + 7'd1;
                    end
                end
                S_CMP: begin
                    batch_cnt_d = batch_cnt_q + 32'd1;
                    if (any_hit && !found_q) begin
                        found_d       = 1'b1;
                        found_nonce_d = nonce_base_q + 32'(win_lane);
                        found_lane_d  = win_lane;
                    end
                    if ((any_hit && stop_on_find) || last_batch) begin
                        state_d = S_FIN;
                    end else begin
                        nonce_base_d = nonce_base_q + LANE_STEP;
                        state_d      = (MIDSTATE_REUSE != 0) ? S_BLK1 : S_BLK0;
                    end
                end
                S_FIN:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        case (state_d)
            S_BLK1:  block_d = 2'd1;
            S_BLK2:  block_d = 2'd2;
            default: block_d = 2'd0;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FIN);
    end

    // nonce_end resets to all ones so lane_valid reads all ones out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            select_q      <= '0;
            block_q       <= '0;
            nonce_base_q  <= '0;
            nonce_end_q   <= '1;
            target_q      <= '0;
            busy_q        <= 1'b0;
            found_q       <= 1'b0;
            found_nonce_q <= '0;
            found_lane_q  <= '0;
            done_q        <= 1'b0;
            batch_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            select_q      <= select_d;
            block_q       <= block_d;
            nonce_base_q  <= nonce_base_d;
            nonce_end_q   <= nonce_end_d;
            target_q      <= target_d;
            busy_q        <= busy_d;
            found_q       <= found_d;
            found_nonce_q <= found_nonce_d;
            found_lane_q  <= found_lane_d;
            done_q        <= done_d;
            batch_cnt_q   <= batch_cnt_d;
        end
    end

    assign select      = select_q;
    assign block       = block_q;
    assign nonce_base  = nonce_base_q;
    assign busy        = busy_q;
    assign found       = found_q;
    assign found_nonce = found_nonce_q;
    assign found_lane  = found_lane_q;
    assign done        = done_q;
    assign batch_cnt   = batch_cnt_q;

endmodule

// File: tb/tb_nonce_search_ctrl.sv
// Directed bench for nonce_search_ctrl: table of whole searches plus hand-written
// abort, reset and start-while-busy sequences.
module tb_nonce_search_ctrl;

    localparam int NL = 10;
    localparam int RD = 64;
    localparam int BL = RD + 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic              stop_on_find;
    logic [31:0]       nonce_start;
    logic [31:0]       nonce_end;
    logic [255:0]      target;
    logic [NL*256-1:0] lane_hash;
    logic [6:0]        select;
    logic [1:0]        block;
    logic [31:0]       nonce_base;
    logic [NL-1:0]     lane_valid;
    logic              busy;
    logic              found;
    logic [31:0]       found_nonce;
    logic [4:0]        found_lane;
    logic              done;
    logic [31:0]       batch_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nonce_search_ctrl #(.NUM_LANES(NL), .ROUNDS(RD), .MIDSTATE_REUSE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .stop_on_find(stop_on_find), .nonce_start(nonce_start), .nonce_end(nonce_end),
        .target(target), .lane_hash(lane_hash), .select(select), .block(block),
        .nonce_base(nonce_base), .lane_valid(lane_valid), .busy(busy), .found(found),
        .found_nonce(found_nonce), .found_lane(found_lane), .done(done), .batch_cnt(batch_cnt)
    );

    typedef struct {
        logic [31:0]   ns;
        logic [31:0]   ne;
        logic [255:0]  tgt;
        logic          stop;
        logic [NL-1:0] hit [4];
        int            done_cyc;
        logic          exp_found;
        logic [31:0]   exp_nonce;
        logic [4:0]    exp_lane;
        logic [31:0]   exp_batches;
        logic [31:0]   exp_base;
        logic [NL-1:0] exp_valid;
    } vec_t;

    vec_t vecs [6];

    function automatic vec_t mkVec(input logic [31:0] ns, input logic [31:0] ne,
                                   input logic [255:0] tgt, input logic stop,
                                   input logic [NL-1:0] h0, input logic [NL-1:0] h1,
                                   input logic [NL-1:0] h2, input logic [NL-1:0] h3,
                                   input int dc, input logic f, input logic [31:0] fn,
                                   input logic [4:0] fl, input logic [31:0] nb,
                                   input logic [31:0] base, input logic [NL-1:0] val);
        vec_t v;
        v.ns = ns; v.ne = ne; v.tgt = tgt; v.stop = stop;
        v.hit[0] = h0; v.hit[1] = h1; v.hit[2] = h2; v.hit[3] = h3;
        v.done_cyc = dc; v.exp_found = f; v.exp_nonce = fn; v.exp_lane = fl;
        v.exp_batches = nb; v.exp_base = base; v.exp_valid = val;
        return v;
    endfunction

    // Cycle k counts from the start-sampling edge; batch 0 compares at 3*BL+1, then every 2*BL+1.
    function automatic int batchOf(input int cyc);
        if (cyc <= 3*BL + 1) return 0;
        return 1 + (cyc - (3*BL + 2)) / (2*BL + 1);
    endfunction

    // A hitting lane presents target-1, every other lane presents exactly target.
    task automatic driveHashes(input vec_t v, input int b);
        for (int i = 0; i < NL; i++) begin
            if (b < 4 && v.hit[b][i]) lane_hash[i*256 +: 256] = v.tgt - 256'd1;
            else                      lane_hash[i*256 +: 256] = v.tgt;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_select"},      32'(select),      32'd0);
        checkOutput({tag, "_block"},       32'(block),       32'd0);
        checkOutput({tag, "_nonce_base"},  nonce_base,       32'd0);
        checkOutput({tag, "_lane_valid"},  32'(lane_valid),  32'h3FF);
        checkOutput({tag, "_busy"},        32'(busy),        32'd0);
        checkOutput({tag, "_found"},       32'(found),       32'd0);
        checkOutput({tag, "_found_nonce"}, found_nonce,      32'd0);
        checkOutput({tag, "_found_lane"},  32'(found_lane),  32'd0);
        checkOutput({tag, "_done"},        32'(done),        32'd0);
        checkOutput({tag, "_batch_cnt"},   batch_cnt,        32'd0);
    endtask

    task automatic startSearch(input vec_t v, output int cyc);
        @(negedge clk);
        nonce_start  = v.ns;
        nonce_end    = v.ne;
        target       = v.tgt;
        stop_on_find = v.stop;
        start        = 1'b1;
        driveHashes(v, 0);
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
    endtask

    task automatic advanceTo(input vec_t v, inout int cyc, input int to, inout int dones);
        while (cyc < to) begin
            driveHashes(v, batchOf(cyc));
            if (done) dones++;
            @(negedge clk);
            cyc++;
        end
        driveHashes(v, batchOf(cyc));
    endtask

    task automatic applyStimulus(input int idx, input vec_t v);
        int  cyc;
        bit  seen;
        string tag;
        tag  = $sformatf("vec%0d", idx);
        seen = 0;
        startSearch(v, cyc);
        while (cyc <= 2000 && !seen) begin
            driveHashes(v, batchOf(cyc));
            if (done) seen = 1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        checkOutput({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            checkOutput({tag, "_done_cycle"},  32'(cyc),        32'(v.done_cyc));
            checkOutput({tag, "_busy_in_fin"}, 32'(busy),       32'd1);
            checkOutput({tag, "_found"},       32'(found),      32'(v.exp_found));
            checkOutput({tag, "_found_nonce"}, found_nonce,     v.exp_nonce);
            checkOutput({tag, "_found_lane"},  32'(found_lane), 32'(v.exp_lane));
            checkOutput({tag, "_batch_cnt"},   batch_cnt,       v.exp_batches);
            checkOutput({tag, "_nonce_base"},  nonce_base,      v.exp_base);
            checkOutput({tag, "_lane_valid"},  32'(lane_valid), 32'(v.exp_valid));
            @(negedge clk);
            checkOutput({tag, "_busy_after"},  32'(busy),       32'd0);
            checkOutput({tag, "_done_after"},  32'(done),       32'd0);
            checkOutput({tag, "_found_hold"},  32'(found),      32'(v.exp_found));
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t v;
        int   cyc;
        int   dones;

        vecs[0] = mkVec(32'd100, 32'd1000, '1, 1'b1, '1, '0, '0, '0,
                        3*BL + 2, 1'b1, 32'd100, 5'd0, 32'd1, 32'd100, 10'h3FF);
        vecs[1] = mkVec(32'd0, 32'd29, '0, 1'b1, '1, '1, '1, '1,
                        3*BL + 2 + 2*(2*BL + 1), 1'b0, 32'd0, 5'd0, 32'd3, 32'd20, 10'h3FF);
        vecs[2] = mkVec(32'd0, 32'd39, 256'd1, 1'b0, '0, 10'b0010001000, 10'b0000000011, '0,
                        3*BL + 2 + 3*(2*BL + 1), 1'b1, 32'd13, 5'd3, 32'd4, 32'd30, 10'h3FF);
        vecs[3] = mkVec(32'd0, 32'd12, 256'd1, 1'b0, '0, 10'b0000100000, '0, '0,
                        3*BL + 2 + (2*BL + 1), 1'b0, 32'd0, 5'd0, 32'd2, 32'd10, 10'b0000000111);
        vecs[4] = mkVec(32'hFFFFFFF8, 32'hFFFFFFFF, 256'd1, 1'b0, 10'b1110000000, '0, '0, '0,
                        3*BL + 2, 1'b1, 32'hFFFFFFFF, 5'd7, 32'd1, 32'hFFFFFFF8, 10'b0011111111);
        vecs[5] = mkVec(32'd5, 32'd4, '1, 1'b1, '1, '0, '0, '0,
                        1, 1'b0, 32'd0, 5'd0, 32'd0, 32'd5, 10'h000);

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; stop_on_find = 1'b0;
        nonce_start = '0; nonce_end = '0; target = '0; lane_hash = '0;
        repeat (2) @(negedge clk);
        checkReset("por");
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            $display("[TB] vector %0d: nonce %0h..%0h", i, vecs[i].ns, vecs[i].ne);
            applyStimulus(i, vecs[i]);
        end

        $display("[TB] abort during second batch");
        v = mkVec(32'd0, 32'd99, 256'd1, 1'b0, 10'b0000000100, '0, '0, '0,
                  0, 1'b0, 32'd0, 5'd0, 32'd0, 32'd0, '0);
        dones = 0;
        startSearch(v, cyc);
        advanceTo(v, cyc, 3*BL + 2 + 10, dones);
        checkOutput("abort_pre_block",  32'(block),  32'd1);
        checkOutput("abort_pre_select", 32'(select), 32'd10);
        abort = 1'b1;
        @(negedge clk);
        cyc++;
        abort = 1'b0;
        checkOutput("abort_busy",        32'(busy),       32'd0);
        checkOutput("abort_select",      32'(select),     32'd0);
        checkOutput("abort_block",       32'(block),      32'd0);
        checkOutput("abort_found",       32'(found),      32'd1);
        checkOutput("abort_found_nonce", found_nonce,     32'd2);
        checkOutput("abort_found_lane",  32'(found_lane), 32'd2);
        checkOutput("abort_batch_cnt",   batch_cnt,       32'd1);
        advanceTo(v, cyc, cyc + 5, dones);
        checkOutput("abort_no_done", 32'(dones), 32'd0);

        $display("[TB] start while busy, then reset in BLK2");
        v = mkVec(32'd0, 32'd99, '0, 1'b0, '0, '0, '0, '0,
                  0, 1'b0, 32'd0, 5'd0, 32'd0, 32'd0, '0);
        dones = 0;
        startSearch(v, cyc);
        advanceTo(v, cyc, 10, dones);
        nonce_start = 32'd500;
        nonce_end   = 32'd600;
        start       = 1'b1;
        advanceTo(v, cyc, 11, dones);
        start = 1'b0;
        checkOutput("busy_start_base",  nonce_base,       32'd0);
        checkOutput("busy_start_valid", 32'(lane_valid), 32'h3FF);
        checkOutput("busy_start_sel",   32'(select),     32'd10);
        advanceTo(v, cyc, BL, dones);
        checkOutput("blk0_last_block",  32'(block),  32'd0);
        checkOutput("blk0_last_select", 32'(select), 32'(BL - 1));
        advanceTo(v, cyc, BL + 1, dones);
        checkOutput("blk1_first_block",  32'(block),  32'd1);
        checkOutput("blk1_first_select", 32'(select), 32'd0);
        advanceTo(v, cyc, 2*BL + 1, dones);
        checkOutput("blk2_first_block",  32'(block),  32'd2);
        checkOutput("blk2_first_select", 32'(select), 32'd0);
        advanceTo(v, cyc, 140, dones);
        rst_n = 1'b0;
        advanceTo(v, cyc, 141, dones);
        checkReset("midrst");
        rst_n = 1'b1;
        advanceTo(v, cyc, 146, dones);
        checkOutput("midrst_busy",    32'(busy),  32'd0);
        checkOutput("midrst_no_done", 32'(dones), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
